// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage.
// Optional misalignment trap is selected with the MEM_ACCESS_MISALIGN_TRAP_EN macro.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MemNone   = 2'd0,
        MemLoad   = 2'd1,
        MemStore  = 2'd2,
        MemOpRsvd = 2'd3
    } memOpT;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeRsvd = 2'd3
    } memSizeT;

    typedef enum logic [1:0] {
        BrNone = 2'd0,
        BrJump = 2'd1,
        BrRsvd = 2'd2,
        BrCond = 2'd3
    } branchTypeT;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDone  = 2'd2,
        StFault = 2'd3
    } stageStateT;

    // Lane indices are carried at a fixed width so the helpers work for any bus width.
    localparam int unsigned LaneIdxW = 8;

    // Force a lane index to the natural alignment of the access size.
    function automatic logic [LaneIdxW-1:0] alignLane(input logic [LaneIdxW-1:0] lane,
                                                       input memSizeT size);
        logic [LaneIdxW-1:0] res;
        case (size)
            SizeByte: res = lane;
            SizeHalf: res = {lane[LaneIdxW-1:1], 1'b0};
            default:  res = '0;
        endcase
        return res;
    endfunction

    // True when the lane index is not naturally aligned for the access size.
    function automatic logic isMisaligned(input logic [LaneIdxW-1:0] lane, input memSizeT size);
        logic res;
        case (size)
            SizeByte: res = 1'b0;
            SizeHalf: res = lane[0];
            default:  res = (lane != '0);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables and store-data shift for a write,
// lane extraction plus zero/sign extension for a read.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANE_BITS  = 2
) (
    input  logic [LANE_BITS-1:0]    lane,
    input  memSizeT                 size,
    input  logic                    loadSigned,
    input  logic [DATA_WIDTH-1:0]   storeData,
    input  logic [DATA_WIDTH-1:0]   loadData,
    output logic [DATA_WIDTH/8-1:0] byteEn,
    output logic [DATA_WIDTH-1:0]   storeLaneData,
    output logic [DATA_WIDTH-1:0]   loadExtData
);
    localparam int unsigned Lanes = DATA_WIDTH / 8;

    logic [LANE_BITS+2:0]  shiftBits;
    logic [DATA_WIDTH-1:0] loadShifted;

    assign shiftBits = {lane, 3'b000};

    // Steer lanes by access size; sub-word reads are right-aligned then extended.
    always_comb begin
        storeLaneData = storeData << shiftBits;
        loadShifted   = loadData >> shiftBits;
        case (size)
            SizeByte: begin
                byteEn      = Lanes'(1) << lane;
                loadExtData = {{(DATA_WIDTH-8){loadSigned & loadShifted[7]}}, loadShifted[7:0]};
            end
            SizeHalf: begin
                byteEn      = Lanes'(3) << lane;
                loadExtData = {{(DATA_WIDTH-16){loadSigned & loadShifted[15]}},
                               loadShifted[15:0]};
            end
            default: begin
                byteEn      = '1;
                loadExtData = loadShifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ack memory port,
// branch/jump resolution, sticky misalignment and timeout faults.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                    ClockInput,
    input  logic                    ResetInputN,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [31:0]             Instruction,
    input  logic [ADDR_WIDTH-1:0]   PCAddress,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic                    ZeroFlag,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [1:0]              MemOp,
    input  logic [1:0]              MemSize,
    input  logic                    LoadSigned,
    input  logic [1:0]              BranchType,
    output logic                    MemReq,
    output logic                    MemWe,
    output logic [ADDR_WIDTH-1:0]   MemAddr,
    output logic [DATA_WIDTH/8-1:0] MemByteEn,
    output logic [DATA_WIDTH-1:0]   MemWData,
    input  logic                    MemAck,
    input  logic [DATA_WIDTH-1:0]   MemRData,
    output logic                    OutValid,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    BranchSignal,
    output logic [ADDR_WIDTH-1:0]   BranchAddress,
    output logic                    MisalignFault,
    output logic                    TimeoutFault
);
    localparam int unsigned Lanes    = DATA_WIDTH / 8;
    localparam int unsigned LaneBits = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned CntW     = $clog2(TIMEOUT + 1);

    stageStateT stateQ, stateD;

    memOpT      opIn;
    memSizeT    sizeIn;
    branchTypeT brIn;
    logic       accept, hasMem, trap, ackInWait, timeoutHit;

    logic [LaneBits-1:0]   rawLane, effLane, laneQ;
    memSizeT               sizeQ;
    logic                  signedQ, weQ, brTakenQ, timeoutFaultQ;
    logic [CntW-1:0]       cntQ, cntD;
    logic [ADDR_WIDTH-1:0] memAddrQ, brAddrQ, jumpTarget, condTarget, condOffset;
    logic [DATA_WIDTH-1:0] wDataQ, readDataQ, laneWData, laneRData;
    logic [Lanes-1:0]      laneByteEn;
    logic                  unusedInstr;

    assign opIn    = memOpT'(MemOp);
    assign sizeIn  = memSizeT'(MemSize);
    assign brIn    = branchTypeT'(BranchType);
    assign accept  = InValid && (stateQ == StIdle);
    assign hasMem  = (opIn == MemLoad) || (opIn == MemStore);
    assign rawLane = Address[LaneBits-1:0];
    assign effLane = LaneBits'(alignLane(LaneIdxW'(rawLane), sizeIn));

    // Ack has priority over the timeout on the final allowed cycle.
    assign ackInWait  = (stateQ == StWait) && MemAck;
    assign timeoutHit = (stateQ == StWait) && !MemAck && (cntQ == CntW'(TIMEOUT - 1));

    assign jumpTarget = {PCAddress[ADDR_WIDTH-1:28], Instruction[25:0], 2'b00};
    assign condOffset = {{(ADDR_WIDTH-18){Instruction[15]}}, Instruction[15:0], 2'b00};
    assign condTarget = PCAddress + ADDR_WIDTH'(4) + condOffset;

    // Opcode bits are decoded upstream; only the offset fields matter here.
    assign unusedInstr = ^Instruction[31:26];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic misalignFaultQ;

    assign trap = hasMem && isMisaligned(LaneIdxW'(rawLane), sizeIn);

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge ClockInput or negedge ResetInputN) begin
        if (!ResetInputN) begin
            misalignFaultQ <= 1'b0;
        end else if (accept && trap) begin
            misalignFaultQ <= 1'b1;
        end
    end

    assign MisalignFault = misalignFaultQ;
`else
    assign trap          = 1'b0;
    assign MisalignFault = 1'b0;
`endif

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge ClockInput or negedge ResetInputN) begin
        if (!ResetInputN) begin
            stateQ        <= StIdle;
            cntQ          <= '0;
            timeoutFaultQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (timeoutHit) begin
                timeoutFaultQ <= 1'b1;
            end
        end
    end

    // Next state and wait-cycle count.
    always_comb begin
        stateD = stateQ;
        cntD   = '0;
        case (stateQ)
            StIdle: begin
                if (InValid) begin
                    if (!hasMem) begin
                        stateD = StDone;
                    end else if (trap) begin
                        stateD = StFault;
                    end else begin
                        stateD = StWait;
                    end
                end
            end
            StWait: begin
                if (MemAck) begin
                    stateD = StDone;
                end else begin
                    cntD = cntQ + 1'b1;
                    if (timeoutHit) begin
                        stateD = StFault;
                    end
                end
            end
            StDone:  stateD = StIdle;
            StFault: stateD = StFault;
            default: stateD = StIdle;
        endcase
    end

    // Capture the operation at accept so the memory request stays stable while waiting.
    always_ff @(posedge ClockInput or negedge ResetInputN) begin
        if (!ResetInputN) begin
            memAddrQ  <= '0;
            laneQ     <= '0;
            sizeQ     <= SizeByte;
            signedQ   <= 1'b0;
            weQ       <= 1'b0;
            wDataQ    <= '0;
            brTakenQ  <= 1'b0;
            brAddrQ   <= '0;
            readDataQ <= '0;
        end else begin
            if (accept) begin
                memAddrQ <= {Address[ADDR_WIDTH-1:LaneBits], {LaneBits{1'b0}}};
                laneQ    <= effLane;
                sizeQ    <= sizeIn;
                signedQ  <= LoadSigned;
                weQ      <= (opIn == MemStore);
                wDataQ   <= WriteData;
                brTakenQ <= (brIn == BrJump) || ((brIn == BrCond) && ZeroFlag);
                case (brIn)
                    BrJump:  brAddrQ <= jumpTarget;
                    BrCond:  brAddrQ <= condTarget;
                    default: brAddrQ <= '0;
                endcase
            end
            if (ackInWait) begin
                readDataQ <= laneRData;
            end
        end
    end

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_BITS  (LaneBits)
    ) u_lane_align (
        .lane          (laneQ),
        .size          (sizeQ),
        .loadSigned    (signedQ),
        .storeData     (wDataQ),
        .loadData      (MemRData),
        .byteEn        (laneByteEn),
        .storeLaneData (laneWData),
        .loadExtData   (laneRData)
    );

    // Moore outputs decoded from state; InReady also drops while reset is held.
    always_comb begin
        InReady      = ResetInputN && (stateQ == StIdle);
        OutValid     = (stateQ == StDone);
        MemReq       = (stateQ == StWait);
        MemWe        = (stateQ == StWait) && weQ;
        MemByteEn    = (stateQ == StWait) ? laneByteEn : '0;
        MemWData     = (stateQ == StWait) ? laneWData : '0;
        BranchSignal = (stateQ == StDone) && brTakenQ;
    end

    assign MemAddr       = memAddrQ;
    assign ReadData      = readDataQ;
    assign BranchAddress = brAddrQ;
    assign TimeoutFault  = timeoutFaultQ;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, hand-written
// multi-cycle sequences and randomized operations against a behavioural model.
module tb_mem_access_stage;

    logic        ClockInput = 1'b0;
    logic        ResetInputN = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] Instruction = '0;
    logic [31:0] PCAddress = '0;
    logic [31:0] Address = '0;
    logic        ZeroFlag = 1'b0;
    logic [31:0] WriteData = '0;
    logic [1:0]  MemOp = '0;
    logic [1:0]  MemSize = '0;
    logic        LoadSigned = 1'b0;
    logic [1:0]  BranchType = '0;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemByteEn;
    logic [31:0] MemWData;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;
    logic        OutValid;
    logic [31:0] ReadData;
    logic        BranchSignal;
    logic [31:0] BranchAddress;
    logic        MisalignFault;
    logic        TimeoutFault;

    int checks = 0;
    int failures = 0;

    mem_access_stage #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (15)
    ) dut (
        .ClockInput    (ClockInput),
        .ResetInputN   (ResetInputN),
        .InValid       (InValid),
        .InReady       (InReady),
        .Instruction   (Instruction),
        .PCAddress     (PCAddress),
        .Address       (Address),
        .ZeroFlag      (ZeroFlag),
        .WriteData     (WriteData),
        .MemOp         (MemOp),
        .MemSize       (MemSize),
        .LoadSigned    (LoadSigned),
        .BranchType    (BranchType),
        .MemReq        (MemReq),
        .MemWe         (MemWe),
        .MemAddr       (MemAddr),
        .MemByteEn     (MemByteEn),
        .MemWData      (MemWData),
        .MemAck        (MemAck),
        .MemRData      (MemRData),
        .OutValid      (OutValid),
        .ReadData      (ReadData),
        .BranchSignal  (BranchSignal),
        .BranchAddress (BranchAddress),
        .MisalignFault (MisalignFault),
        .TimeoutFault  (TimeoutFault)
    );

    always #5 ClockInput = ~ClockInput;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  bt;
        logic        zero;
        logic [31:0] pc;
        logic [31:0] instr;
        int          ackDelay;
        logic [3:0]  expBe;
        logic [31:0] expAddr;
        logic [31:0] expWData;
        logic [31:0] expRData;
        logic        expBr;
        logic [31:0] expBrAddr;
    } opVec_t;

    opVec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] laneMask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Reference model: expected bus and result values from address/size arithmetic.
    function automatic opVec_t model(input opVec_t v);
        opVec_t r;
        longint unsigned lane, nbytes, span, raw, imm;
        longint off;
        r = v;
        lane = longint'(v.addr % 4);
        if (v.size == 2'd1) lane = lane - (lane % 2);
        else if (v.size >= 2'd2) lane = 0;
        nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        span = 64'd1 << (8 * nbytes);
        r.expAddr  = v.addr - (v.addr % 4);
        r.expBe    = 4'(((64'd1 << nbytes) - 1) << lane);
        r.expWData = 32'((longint'(v.wdata) % span) << (8 * lane));
        raw = (longint'(v.rdata) >> (8 * lane)) % span;
        if (v.sgn && raw >= span / 2) raw = raw + (64'h1_0000_0000 - span);
        r.expRData = 32'(raw);
        r.expBr = (v.bt == 2'd1) || (v.bt == 2'd3 && v.zero);
        if (v.bt == 2'd1) begin
            r.expBrAddr = (v.pc & 32'hF000_0000) | 32'((longint'(v.instr) % 64'h400_0000) * 4);
        end else begin
            imm = longint'(v.instr) % 65536;
            off = (imm >= 32768) ? longint'(imm) - 65536 : longint'(imm);
            r.expBrAddr = 32'(longint'(v.pc) + 4 + off * 4);
        end
        return r;
    endfunction

    task automatic present(input opVec_t v);
        Instruction = v.instr;
        PCAddress   = v.pc;
        Address     = v.addr;
        ZeroFlag    = v.zero;
        WriteData   = v.wdata;
        MemOp       = v.op;
        MemSize     = v.size;
        LoadSigned  = v.sgn;
        BranchType  = v.bt;
        InValid     = 1'b1;
    endtask

    // Change every op input after accept so the DUT must rely on its own registers.
    task automatic scramble();
        InValid     = 1'b0;
        Instruction = $urandom;
        PCAddress   = $urandom;
        Address     = $urandom;
        ZeroFlag    = 1'($urandom);
        WriteData   = $urandom;
        MemOp       = 2'($urandom);
        MemSize     = 2'($urandom);
        LoadSigned  = 1'($urandom);
        BranchType  = 2'($urandom);
    endtask

    task automatic pulseReset();
        ResetInputN = 1'b0;
        #2;
        ResetInputN = 1'b1;
        @(posedge ClockInput);
        #1;
    endtask

    // Issue one op, acknowledge after ackDelay request cycles, check result and timing.
    task automatic doOp(input opVec_t v, input string tag);
        int n;
        logic stable;
        logic isMem;
        isMem = (v.op == 2'd1) || (v.op == 2'd2);
        n = 0;
        while (InReady !== 1'b1 && n < 40) begin
            @(posedge ClockInput);
            #1;
            n++;
        end
        check({tag, ".ready"}, InReady, 1);
        present(v);
        @(posedge ClockInput);
        #1;
        scramble();
        if (isMem) begin
            check({tag, ".req"}, MemReq, 1);
            check({tag, ".we"}, MemWe, (v.op == 2'd2));
            check({tag, ".addr"}, MemAddr, v.expAddr);
            check({tag, ".be"}, MemByteEn, v.expBe);
            if (v.op == 2'd2) check({tag, ".wdata"}, MemWData & laneMask(v.expBe), v.expWData);
            stable = 1'b1;
            for (int i = 0; i < v.ackDelay; i++) begin
                @(posedge ClockInput);
                #1;
                if (MemReq !== 1'b1 || MemAddr !== v.expAddr || MemByteEn !== v.expBe ||
                    OutValid !== 1'b0) stable = 1'b0;
            end
            check({tag, ".hold"}, stable, 1);
            MemAck   = 1'b1;
            MemRData = v.rdata;
            @(posedge ClockInput);
            #1;
            MemAck   = 1'b0;
            MemRData = $urandom;
        end
        check({tag, ".outValid"}, OutValid, 1);
        check({tag, ".reqDone"}, MemReq, 0);
        check({tag, ".brSig"}, BranchSignal, v.expBr);
        if (v.expBr) check({tag, ".brAddr"}, BranchAddress, v.expBrAddr);
        if (v.op == 2'd1) check({tag, ".rdata"}, ReadData, v.expRData);
        @(posedge ClockInput);
        #1;
        check({tag, ".pulse"}, OutValid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        opVec_t v;

        tbl[0] = '{op:2, size:2, addr:32'h100, wdata:32'hDEADBEEF, ackDelay:3, expBe:4'hF,
                   expAddr:32'h100, expWData:32'hDEADBEEF, default:0};
        tbl[1] = '{op:1, size:0, sgn:1, addr:32'h103, rdata:32'h80123456, ackDelay:1,
                   expBe:4'h8, expAddr:32'h100, expRData:32'hFFFFFF80, default:0};
        tbl[2] = '{op:1, size:0, sgn:0, addr:32'h103, rdata:32'h80123456, ackDelay:0,
                   expBe:4'h8, expAddr:32'h100, expRData:32'h00000080, default:0};
        tbl[3] = '{op:0, bt:3, zero:1, pc:32'h40, instr:32'h0000FFFF, expBr:1,
                   expBrAddr:32'h40, default:0};
        tbl[4] = '{op:0, bt:1, pc:32'hA0000010, instr:32'h0BFFFFFF, expBr:1,
                   expBrAddr:32'hAFFFFFFC, default:0};
        tbl[5] = '{op:1, size:1, sgn:1, addr:32'h202, rdata:32'h80011234, ackDelay:2, bt:3,
                   zero:1, pc:32'hFFFFFFF8, instr:32'h00000001, expBe:4'hC, expAddr:32'h200,
                   expRData:32'hFFFF8001, expBr:1, expBrAddr:32'h0, default:0};
        tbl[6] = '{op:2, size:1, addr:32'h6, wdata:32'h1234ABCD, ackDelay:1, bt:3, zero:0,
                   pc:32'h100, instr:32'h10, expBe:4'hC, expAddr:32'h4, expWData:32'hABCD0000,
                   default:0};
        tbl[7] = '{op:2, size:0, addr:32'h1, wdata:32'h00000055, bt:2, zero:1, expBe:4'h2,
                   expAddr:32'h0, expWData:32'h00005500, default:0};
        tbl[8] = '{op:1, size:1, sgn:0, addr:32'h100, rdata:32'h1234FEDC, expBe:4'h3,
                   expAddr:32'h100, expRData:32'h0000FEDC, default:0};
        tbl[9] = '{op:1, size:2, sgn:1, addr:32'h10, rdata:32'h89ABCDEF, ackDelay:14,
                   expBe:4'hF, expAddr:32'h10, expRData:32'h89ABCDEF, default:0};

        // Reset state
        #1;
        check("rst.inReady", InReady, 0);
        check("rst.memReq", MemReq, 0);
        check("rst.outValid", OutValid, 0);
        check("rst.faults", {MisalignFault, TimeoutFault}, 0);
        check("rst.memAddr", MemAddr, 0);
        @(negedge ClockInput);
        ResetInputN = 1'b1;
        @(posedge ClockInput);
        #1;
        check("idle.inReady", InReady, 1);
        check("idle.memReq", MemReq, 0);

        // Directed vectors
        for (int i = 0; i < 10; i++) doOp(tbl[i], $sformatf("vec%0d", i));
        check("ackWins.timeoutFault", TimeoutFault, 0);

        // MemAck while idle is ignored
        MemAck = 1'b1;
        @(posedge ClockInput);
        #1;
        @(posedge ClockInput);
        #1;
        MemAck = 1'b0;
        check("idleAck.outValid", OutValid, 0);
        check("idleAck.memReq", MemReq, 0);
        check("idleAck.inReady", InReady, 1);

        // InValid while busy is ignored
        v = '{op:2, size:2, addr:32'h500, wdata:32'h11223344, default:0};
        present(v);
        @(posedge ClockInput);
        #1;
        v = '{op:0, bt:1, pc:32'h1000, instr:32'h0000_0100, default:0};
        present(v);
        check("busy.inReady", InReady, 0);
        MemAck = 1'b1;
        @(posedge ClockInput);
        #1;
        MemAck = 1'b0;
        InValid = 1'b0;
        check("busy.outValid", OutValid, 1);
        check("busy.brSig", BranchSignal, 0);
        @(posedge ClockInput);
        #1;
        check("busy.noExtra", OutValid, 0);

        // Misaligned half load
        v = '{op:1, size:1, sgn:0, addr:32'h101, rdata:32'hAAAA5678, ackDelay:1, expBe:4'h3,
              expAddr:32'h100, expRData:32'h00005678, default:0};
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        present(v);
        @(posedge ClockInput);
        #1;
        scramble();
        check("mis.memReq", MemReq, 0);
        check("mis.fault", MisalignFault, 1);
        check("mis.inReady", InReady, 0);
        @(posedge ClockInput);
        #1;
        check("mis.stuck", {InReady, MemReq, OutValid}, 0);
        pulseReset();
        check("mis.cleared", MisalignFault, 0);
`else
        doOp(v, "mis");
        check("mis.noFault", MisalignFault, 0);
`endif

        // Timeout: no ack for TIMEOUT request cycles
        v = '{op:2, size:2, addr:32'h300, wdata:32'hCAFEF00D, default:0};
        present(v);
        @(posedge ClockInput);
        #1;
        scramble();
        for (int i = 1; i < 15; i++) begin
            @(posedge ClockInput);
            #1;
        end
        check("to.lastReq", MemReq, 1);
        check("to.notYet", TimeoutFault, 0);
        @(posedge ClockInput);
        #1;
        check("to.fault", TimeoutFault, 1);
        check("to.reqDropped", MemReq, 0);
        check("to.inReady", InReady, 0);
        v = '{op:0, bt:1, default:0};
        present(v);
        MemAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge ClockInput);
            #1;
            check($sformatf("to.stuck%0d", i), {InReady, OutValid, TimeoutFault}, 3'b001);
        end
        InValid = 1'b0;
        MemAck  = 1'b0;
        pulseReset();
        check("to.cleared", TimeoutFault, 0);
        check("to.ready", InReady, 1);

        // Reset in the middle of a wait
        v = '{op:1, size:2, addr:32'h400, rdata:32'h0, default:0};
        present(v);
        @(posedge ClockInput);
        #1;
        scramble();
        @(posedge ClockInput);
        #1;
        check("rw.req", MemReq, 1);
        ResetInputN = 1'b0;
        #1;
        check("rw.memReq", MemReq, 0);
        check("rw.bus", {MemWe, MemAddr, MemByteEn, MemWData}, 0);
        check("rw.outs", {InReady, OutValid, BranchSignal, ReadData, BranchAddress}, 0);
        #1;
        ResetInputN = 1'b1;
        @(posedge ClockInput);
        #1;
        doOp(tbl[1], "rw.after");

        // Randomized operations against the model
        for (int k = 0; k < 40; k++) begin
            v = '{default:0};
            v.op       = 2'($urandom_range(0, 2));
            v.size     = 2'($urandom_range(0, 2));
            v.sgn      = 1'($urandom);
            v.addr     = $urandom;
            v.wdata    = $urandom;
            v.rdata    = $urandom;
            v.bt       = 2'($urandom);
            v.zero     = 1'($urandom);
            v.pc       = $urandom;
            v.instr    = $urandom;
            v.ackDelay = $urandom_range(0, 6);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            if (v.size == 2'd1) v.addr[0] = 1'b0;
            else if (v.size == 2'd2) v.addr[1:0] = 2'b00;
`endif
            v = model(v);
            doOp(v, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
